// File: rtl/zorgian_change_dispenser.sv
// zorgian_change_dispenser
// Coin change dispenser with a small pentagon/triangle/circle inventory.
// A transaction latches cost and paid and classifies the payment. It can be
// short (cough_up), exact (exact), or an overpayment. For an overpayment the
// change is paid out greedily, one coin per cycle. Payout stops when the
// change reaches zero, the per-transaction coin limit is hit, or no coin fits.
//
// Ports
//   CLOCK_100                        system clock, rising-edge
//   reset_L                          asynchronous active-low reset
//   load, load_pent/tri/circ         inventory load (IDLE only)
//   start, cost, paid                transaction request and operands
//   busy                             high in every state except IDLE
//   coin_valid, coin                 one coin per cycle while dispensing
//   done                             one-cycle end-of-transaction strobe
//   remaining                        change left, or amount owed on cough_up
//   exact, not_enough, cough_up      result flags (at most one set)
//   pent_cnt, tri_cnt, circ_cnt      current inventory
module zorgian_change_dispenser #(
  parameter int VAL_W     = 4,
  parameter int CNT_W     = 2,
  parameter int MAX_COINS = 2
) (
  input  logic             CLOCK_100,
  input  logic             reset_L,
  input  logic             load,
  input  logic [CNT_W-1:0] load_pent,
  input  logic [CNT_W-1:0] load_tri,
  input  logic [CNT_W-1:0] load_circ,
  input  logic             start,
  input  logic [VAL_W-1:0] cost,
  input  logic [VAL_W-1:0] paid,
  output logic             busy,
  output logic             coin_valid,
  output logic [2:0]       coin,
  output logic             done,
  output logic [VAL_W-1:0] remaining,
  output logic             exact,
  output logic             not_enough,
  output logic             cough_up,
  output logic [CNT_W-1:0] pent_cnt,
  output logic [CNT_W-1:0] tri_cnt,
  output logic [CNT_W-1:0] circ_cnt
);

  localparam logic [3:0] MAX_C = 4'(MAX_COINS);

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_PENT = 3'b101;
  localparam logic [2:0] COIN_TRI  = 3'b011;
  localparam logic [2:0] COIN_CIRC = 3'b001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [VAL_W-1:0] cost_q;
  logic [VAL_W-1:0] paid_q;
  logic [3:0]       disp_cnt;
  logic [2:0]       sel_coin;
  logic [VAL_W-1:0] sel_val;

  // Greedy coin choice: largest denomination that fits and is in stock.
  always_comb begin
    sel_coin = COIN_NONE;
    sel_val  = '0;
    if ((pent_cnt != {CNT_W{1'b0}}) && (remaining >= VAL_W'(5))) begin
      sel_coin = COIN_PENT;
      sel_val  = VAL_W'(5);
    end else if ((tri_cnt != {CNT_W{1'b0}}) && (remaining >= VAL_W'(3))) begin
      sel_coin = COIN_TRI;
      sel_val  = VAL_W'(3);
    end else if ((circ_cnt != {CNT_W{1'b0}}) && (remaining >= VAL_W'(1))) begin
      sel_coin = COIN_CIRC;
      sel_val  = VAL_W'(1);
    end else begin
      sel_coin = COIN_NONE;
      sel_val  = '0;
    end
  end

  // Next-state and strobe decode. Strobes depend on state and registers only.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    coin_valid = 1'b0;
    coin       = COIN_NONE;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // load has priority; a simultaneous start is dropped.
        if (load) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = CHECK;
        end else begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (paid_q > cost_q) begin
          state_next = DISPENSE;
        end else begin
          state_next = DONE;
        end
      end
      DISPENSE: begin
        if (remaining == '0) begin
          state_next = DONE;
        end else if (disp_cnt == MAX_C) begin
          state_next = DONE;
        end else if (sel_coin == COIN_NONE) begin
          state_next = DONE;
        end else begin
          coin_valid = 1'b1;
          coin       = sel_coin;
          state_next = DISPENSE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_100 or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands, result registers, coin counter and inventory.
  always_ff @(posedge CLOCK_100 or negedge reset_L) begin
    if (!reset_L) begin
      cost_q     <= '0;
      paid_q     <= '0;
      disp_cnt   <= 4'd0;
      remaining  <= '0;
      exact      <= 1'b0;
      not_enough <= 1'b0;
      cough_up   <= 1'b0;
      pent_cnt   <= '0;
      tri_cnt    <= '0;
      circ_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            pent_cnt <= load_pent;
            tri_cnt  <= load_tri;
            circ_cnt <= load_circ;
          end else if (start) begin
            cost_q     <= cost;
            paid_q     <= paid;
            remaining  <= '0;
            exact      <= 1'b0;
            not_enough <= 1'b0;
            cough_up   <= 1'b0;
          end
        end
        CHECK: begin
          // Subtract only in the direction the compare allows.
          if (paid_q < cost_q) begin
            cough_up  <= 1'b1;
            remaining <= cost_q - paid_q;
          end else if (paid_q == cost_q) begin
            exact     <= 1'b1;
            remaining <= '0;
          end else begin
            remaining <= paid_q - cost_q;
            disp_cnt  <= 4'd0;
          end
        end
        DISPENSE: begin
          if (coin_valid) begin
            remaining <= remaining - sel_val;
            disp_cnt  <= disp_cnt + 4'd1;
            case (sel_coin)
              COIN_PENT: pent_cnt <= pent_cnt - CNT_W'(1);
              COIN_TRI:  tri_cnt  <= tri_cnt - CNT_W'(1);
              COIN_CIRC: circ_cnt <= circ_cnt - CNT_W'(1);
              default:   pent_cnt <= pent_cnt;
            endcase
          end else if (remaining != '0) begin
            // Limit reached or nothing fits; coins already paid stay paid.
            not_enough <= 1'b1;
          end
        end
        DONE: begin
          remaining <= remaining;
        end
        default: begin
          remaining <= remaining;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zorgian_change_dispenser.sv
// Directed self-checking bench for zorgian_change_dispenser (default params).
// Outputs are sampled on the falling clock edge. "j" counts rising edges after
// the edge T that sampled start. Cycle T+k of the timing rules is observed at
// j = k-1. So coins appear at j=1..N and done at j=N+2, or at j=1 without coins.
module tb_zorgian_change_dispenser;

  logic       CLOCK_100 = 1'b0;
  logic       reset_L;
  logic       load;
  logic [1:0] load_pent, load_tri, load_circ;
  logic       start;
  logic [3:0] cost, paid;
  logic       busy, coin_valid, done, exact, not_enough, cough_up;
  logic [2:0] coin;
  logic [3:0] remaining;
  logic [1:0] pent_cnt, tri_cnt, circ_cnt;

  int tests = 0;
  int fails = 0;

  logic [2:0] coin_log [8];
  int         coin_at  [8];
  int         n_coins;
  int         done_at;

  always #5 CLOCK_100 = ~CLOCK_100;

  zorgian_change_dispenser #(.VAL_W(4), .CNT_W(2), .MAX_COINS(2)) dut (
    .CLOCK_100(CLOCK_100), .reset_L(reset_L), .load(load),
    .load_pent(load_pent), .load_tri(load_tri), .load_circ(load_circ),
    .start(start), .cost(cost), .paid(paid), .busy(busy),
    .coin_valid(coin_valid), .coin(coin), .done(done), .remaining(remaining),
    .exact(exact), .not_enough(not_enough), .cough_up(cough_up),
    .pent_cnt(pent_cnt), .tri_cnt(tri_cnt), .circ_cnt(circ_cnt)
  );

  task automatic do_load(input logic [1:0] p, input logic [1:0] t, input logic [1:0] c);
    @(negedge CLOCK_100);
    load = 1'b1; load_pent = p; load_tri = t; load_circ = c;
    @(negedge CLOCK_100);
    load = 1'b0;
  endtask

  // Issue one transaction and log coins and the done cycle (bounded wait).
  task automatic run_txn(input logic [3:0] c, input logic [3:0] p, input bit glitch);
    n_coins = 0;
    done_at = -1;
    @(negedge CLOCK_100);
    cost = c; paid = p; start = 1'b1;
    @(negedge CLOCK_100);
    start = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge CLOCK_100);
      if (glitch && j == 1) begin
        start = 1'b1; load = 1'b1;
        load_pent = 2'd3; load_tri = 2'd3; load_circ = 2'd3;
        cost = 4'd1; paid = 4'd15;
      end else begin
        start = 1'b0; load = 1'b0;
      end
      if (coin_valid && n_coins < 8) begin
        coin_log[n_coins] = coin;
        coin_at[n_coins]  = j;
        n_coins++;
      end
      if (done) begin
        done_at = j;
        break;
      end
    end
    start = 1'b0; load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if ({busy, coin_valid, coin, done} !== 6'b0) begin fails++; $display("FAIL reset_strobes: got %b expected 000000", {busy, coin_valid, coin, done}); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0) begin fails++; $display("FAIL reset_results: got %b expected 0000000", {remaining, exact, not_enough, cough_up}); end
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b0) begin fails++; $display("FAIL reset_counts: got %b expected 000000", {pent_cnt, tri_cnt, circ_cnt}); end
    @(negedge CLOCK_100);
    reset_L = 1'b1;
  endtask

  task automatic test_change();
    do_load(2'd1, 2'd1, 2'd1);
    run_txn(4'd4, 4'd12, 1'b0);
    tests++; if (n_coins !== 2) begin fails++; $display("FAIL change_ncoins: got %0d expected 2", n_coins); end
    tests++; if (n_coins >= 2 && (coin_log[0] !== 3'b101 || coin_at[0] !== 1)) begin fails++; $display("FAIL change_coin0: got %b at j=%0d expected 101 at j=1", coin_log[0], coin_at[0]); end
    tests++; if (n_coins >= 2 && (coin_log[1] !== 3'b011 || coin_at[1] !== 2)) begin fails++; $display("FAIL change_coin1: got %b at j=%0d expected 011 at j=2", coin_log[1], coin_at[1]); end
    tests++; if (done_at !== 4) begin fails++; $display("FAIL change_done_at: got %0d expected 4", done_at); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0) begin fails++; $display("FAIL change_result: got %b expected 0000000", {remaining, exact, not_enough, cough_up}); end
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b00_00_01) begin fails++; $display("FAIL change_counts: got %b expected 000001", {pent_cnt, tri_cnt, circ_cnt}); end
    @(negedge CLOCK_100);
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL change_idle_after: got busy,done=%b expected 00", {busy, done}); end
  endtask

  task automatic test_exact();
    run_txn(4'd7, 4'd7, 1'b0);
    tests++; if (n_coins !== 0) begin fails++; $display("FAIL exact_ncoins: got %0d expected 0", n_coins); end
    tests++; if (done_at !== 1) begin fails++; $display("FAIL exact_done_at: got %0d expected 1", done_at); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0000_100) begin fails++; $display("FAIL exact_result: got %b expected 0000100", {remaining, exact, not_enough, cough_up}); end
  endtask

  task automatic test_cough_up();
    run_txn(4'd9, 4'd3, 1'b0);
    tests++; if (n_coins !== 0) begin fails++; $display("FAIL cough_ncoins: got %0d expected 0", n_coins); end
    tests++; if (done_at !== 1) begin fails++; $display("FAIL cough_done_at: got %0d expected 1", done_at); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0110_001) begin fails++; $display("FAIL cough_result: got %b expected 0110001", {remaining, exact, not_enough, cough_up}); end
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b00_00_01) begin fails++; $display("FAIL cough_counts: got %b expected 000001", {pent_cnt, tri_cnt, circ_cnt}); end
    repeat (2) @(negedge CLOCK_100);
    tests++; if ({busy, remaining, cough_up} !== 6'b0_0110_1) begin fails++; $display("FAIL cough_hold: got %b expected 001101", {busy, remaining, cough_up}); end
  endtask

  task automatic test_not_enough();
    do_load(2'd0, 2'd0, 2'd3);
    run_txn(4'd0, 4'd4, 1'b0);
    tests++; if (n_coins !== 2) begin fails++; $display("FAIL short_ncoins: got %0d expected 2", n_coins); end
    tests++; if (n_coins >= 2 && ({coin_log[0], coin_log[1]} !== 6'b001_001)) begin fails++; $display("FAIL short_coins: got %b %b expected 001 001", coin_log[0], coin_log[1]); end
    tests++; if (done_at !== 4) begin fails++; $display("FAIL short_done_at: got %0d expected 4", done_at); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0010_010) begin fails++; $display("FAIL short_result: got %b expected 0010010", {remaining, exact, not_enough, cough_up}); end
    tests++; if (circ_cnt !== 2'd1) begin fails++; $display("FAIL short_circ_cnt: got %0d expected 1", circ_cnt); end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    do_load(2'd1, 2'd1, 2'd1);
    @(negedge CLOCK_100);
    cost = 4'd4; paid = 4'd12; start = 1'b1;
    @(negedge CLOCK_100);
    start = 1'b0;
    @(negedge CLOCK_100);
    tests++; if ({coin_valid, coin} !== 4'b1_101) begin fails++; $display("FAIL rstmid_first_coin: got %b expected 1101", {coin_valid, coin}); end
    @(negedge CLOCK_100);
    reset_L = 1'b0;
    #1;
    tests++; if ({busy, coin_valid, coin, done, remaining, exact, not_enough, cough_up} !== 13'b0) begin fails++; $display("FAIL rstmid_outputs: got %b expected all 0", {busy, coin_valid, coin, done, remaining, exact, not_enough, cough_up}); end
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b0) begin fails++; $display("FAIL rstmid_counts: got %b expected 000000", {pent_cnt, tri_cnt, circ_cnt}); end
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge CLOCK_100); #1;
      if (done) seen_done = 1'b1;
    end
    @(negedge CLOCK_100);
    reset_L = 1'b1;
    load = 1'b1; load_pent = 2'd2; load_tri = 2'd0; load_circ = 2'd0;
    @(negedge CLOCK_100);
    load = 1'b0;
    if (done) seen_done = 1'b1;
    tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL rstmid_no_done: got %b expected 0", seen_done); end
    tests++; if ({busy, pent_cnt} !== 3'b0_10) begin fails++; $display("FAIL rstmid_load_after: got busy,pent=%b expected 010", {busy, pent_cnt}); end
  endtask

  task automatic test_ignore_busy();
    // P=2 from the previous load; the start and load pulses land while busy.
    run_txn(4'd0, 4'd5, 1'b1);
    tests++; if (n_coins !== 1) begin fails++; $display("FAIL busy_ncoins: got %0d expected 1", n_coins); end
    tests++; if (n_coins >= 1 && coin_log[0] !== 3'b101) begin fails++; $display("FAIL busy_coin: got %b expected 101", coin_log[0]); end
    tests++; if (done_at !== 3) begin fails++; $display("FAIL busy_done_at: got %0d expected 3", done_at); end
    tests++; if ({remaining, exact, not_enough, cough_up} !== 7'b0) begin fails++; $display("FAIL busy_result: got %b expected 0000000", {remaining, exact, not_enough, cough_up}); end
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b01_00_00) begin fails++; $display("FAIL busy_counts: got %b expected 010000", {pent_cnt, tri_cnt, circ_cnt}); end
    repeat (2) @(negedge CLOCK_100);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_no_restart: got %b expected 0", busy); end
  endtask

  task automatic test_load_start_together();
    @(negedge CLOCK_100);
    load = 1'b1; start = 1'b1; cost = 4'd0; paid = 4'd5;
    load_pent = 2'd1; load_tri = 2'd2; load_circ = 2'd3;
    @(negedge CLOCK_100);
    load = 1'b0; start = 1'b0;
    tests++; if ({pent_cnt, tri_cnt, circ_cnt} !== 6'b01_10_11) begin fails++; $display("FAIL both_counts: got %b expected 011011", {pent_cnt, tri_cnt, circ_cnt}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL both_busy: got %b expected 0", busy); end
    @(negedge CLOCK_100);
    tests++; if ({busy, coin_valid, done} !== 3'b000) begin fails++; $display("FAIL both_stays_idle: got %b expected 000", {busy, coin_valid, done}); end
  endtask

  initial begin
    reset_L = 1'b0; load = 1'b0; start = 1'b0;
    load_pent = 2'd0; load_tri = 2'd0; load_circ = 2'd0;
    cost = 4'd0; paid = 4'd0;
    test_reset();
    test_change();
    test_exact();
    test_cough_up();
    test_not_enough();
    test_reset_mid();
    test_ignore_busy();
    test_load_start_together();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
